// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-level round-robin arbiter for the async FIFO write port
module fifo_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                wclk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_last,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  input  logic                full,
  output logic                wr_en,
  output logic [IDW+DW-1:0]   wdata,
  output logic [NREQ-1:0]     grant,
  output logic                abort,
  output logic                busy
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t          state_q, state_d;
  logic [IDW-1:0]  gid_q, gid_d, ptr_q, ptr_d, win, gid_nxt;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            abort_q, abort_d, busy_q, busy_d;
  logic            lock, gvalid, done, wd;
  logic [IDW:0]    s;
  // rotating priority scan: lowest offset from ptr with valid asserted wins
  always_comb begin
    win = ptr_q;
    s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      s = {1'b0, ptr_q} + (IDW+1)'(i);
      s = (s >= (IDW+1)'(NREQ)) ? s - (IDW+1)'(NREQ) : s;
      win = req_valid[s[IDW-1:0]] ? s[IDW-1:0] : win;
    end
  end
  // datapath to the FIFO and next-state for the packet lock and watchdog
  always_comb begin
    lock       = state_q == LOCK;
    gvalid     = req_valid[gid_q];
    wr_en      = lock & gvalid & ~full;
    req_ready  = (lock && !full) ? NREQ'(1) << gid_q : '0;
    wdata      = lock ? {gid_q, req_data[int'(gid_q)*DW +: DW]} : '0;
    done       = wr_en & req_last[gid_q];
    wd         = lock & ~gvalid & (idle_cnt_q == CW'(TIMEOUT - 1));
    gid_nxt    = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + IDW'(1);
    state_d    = lock ? ((done | wd) ? IDLE : LOCK) : (|req_valid ? LOCK : IDLE);
    gid_d      = (!lock && |req_valid) ? win : gid_q;
    ptr_d      = (done | wd) ? gid_nxt : ptr_q;
    idle_cnt_d = (lock && !gvalid && !wd) ? idle_cnt_q + CW'(1) : '0;
    abort_d    = wd;
    busy_d     = state_d == LOCK;
    grant_d    = busy_d ? NREQ'(1) << gid_d : '0;
  end
  // state and registered outputs; reset clears any partial packet
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gid_q      <= '0;
      ptr_q      <= '0;
      idle_cnt_q <= '0;
      grant_q    <= '0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gid_q      <= gid_d;
      ptr_q      <= ptr_d;
      idle_cnt_q <= idle_cnt_d;
      grant_q    <= grant_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
    end
  end
  assign grant = grant_q;
  assign abort = abort_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenario checks for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  logic        wclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0, req_last = '0, req_ready, grant;
  logic [31:0] req_data = '0;
  logic        full = 1'b0, wr_en, abort, busy;
  logic [9:0]  wdata, ew;
  logic [3:0]  eg, b, acc;
  int          checks = 0, failures = 0;
  int          j, p, nb, nr;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .IDW(2), .TIMEOUT(16)) dut (
    .wclk(wclk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .full(full), .wr_en(wr_en),
    .wdata(wdata), .grant(grant), .abort(abort), .busy(busy));

  always #5 wclk = ~wclk;

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    req_data[i*8 +: 8] = d;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '1; req_data = 32'hDEADBEEF;
    tick; tick; #1;
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%h exp=0", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (abort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b exp=0", abort); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
    checks++; if (wdata !== 10'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    req_valid = '0;
  endtask

  task automatic test_single;
    do_reset;
    req_valid = 4'b0100; set_data(2, 8'hA1); #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL single_idle_wr_en got=%b exp=0", wr_en); end
    tick; #1;
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", grant); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    checks++; if (wdata !== 10'h2A1) begin failures++; $display("FAIL single_beat1 got=%h exp=2a1", wdata); end
    tick; set_data(2, 8'hA2); #1;
    checks++; if (wdata !== 10'h2A2 || wr_en !== 1'b1) begin failures++; $display("FAIL single_beat2 got=%h/%b exp=2a2/1", wdata, wr_en); end
    tick; set_data(2, 8'hA3); req_last = 4'b0100; #1;
    checks++; if (wdata !== 10'h2A3 || wr_en !== 1'b1) begin failures++; $display("FAIL single_beat3 got=%h/%b exp=2a3/1", wdata, wr_en); end
    tick; req_valid = '0; req_last = '0; #1;
    checks++; if (busy !== 1'b0 || grant !== 4'b0) begin failures++; $display("FAIL single_release got=%b/%b exp=0/0000", busy, grant); end
    checks++; if (dut.ptr_q !== 2'd3) begin failures++; $display("FAIL single_ptr got=%0d exp=3", dut.ptr_q); end
  endtask

  task automatic test_round_robin;
    do_reset;
    b = '0;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) set_data(i, 8'(i * 16) + {7'd0, b[i]});
      req_last = b; req_valid = '1; #1;
      j = (k - 1) / 3; p = (k - 1) % 3;
      eg = (k == 0 || p == 2) ? 4'b0 : 4'(1 << (j % 4));
      checks++; if (grant !== eg) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", k, grant, eg); end
      if (k > 0 && p < 2) begin
        ew = {2'(j % 4), 8'((j % 4) * 16 + p)};
        checks++; if (wdata !== ew || wr_en !== 1'b1) begin failures++; $display("FAIL rr_wdata cyc=%0d got=%h/%b exp=%h/1", k, wdata, wr_en, ew); end
      end
      acc = req_valid & req_ready;
      tick;
      b = b ^ acc;
    end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_backpressure;
    do_reset;
    req_valid = 4'b0010; set_data(1, 8'h11); #1;
    tick; #1;
    checks++; if (wdata !== 10'h111 || wr_en !== 1'b1) begin failures++; $display("FAIL bp_beat1 got=%h/%b exp=111/1", wdata, wr_en); end
    tick; set_data(1, 8'h12); full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL bp_wr_en cyc=%0d got=%b exp=0", k, wr_en); end
      checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", k, req_ready); end
      checks++; if (abort !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bp_state cyc=%0d got=%b/%b exp=0/1", k, abort, busy); end
      tick;
    end
    full = 1'b0; #1;
    checks++; if (wdata !== 10'h112 || wr_en !== 1'b1) begin failures++; $display("FAIL bp_beat2 got=%h/%b exp=112/1", wdata, wr_en); end
    tick; set_data(1, 8'h13); req_last = 4'b0010; #1;
    checks++; if (wdata !== 10'h113 || wr_en !== 1'b1) begin failures++; $display("FAIL bp_beat3 got=%h/%b exp=113/1", wdata, wr_en); end
    tick; req_valid = '0; req_last = '0; #1;
    checks++; if (busy !== 1'b0 || abort !== 1'b0) begin failures++; $display("FAIL bp_end got=%b/%b exp=0/0", busy, abort); end
  endtask

  task automatic test_watchdog;
    do_reset;
    req_valid = 4'b0101; set_data(0, 8'h55); set_data(2, 8'h77); #1;
    tick; #1;
    checks++; if (grant !== 4'b0001 || wr_en !== 1'b1) begin failures++; $display("FAIL wd_first got=%b/%b exp=0001/1", grant, wr_en); end
    tick; req_valid = 4'b0100;
    for (int k = 2; k < 18; k++) begin
      #1;
      checks++; if (abort !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL wd_wait cyc=%0d got=%b/%b exp=0/1", k, abort, busy); end
      checks++; if (req_ready !== 4'b0001 || wr_en !== 1'b0) begin failures++; $display("FAIL wd_ready cyc=%0d got=%b/%b exp=0001/0", k, req_ready, wr_en); end
      tick;
    end
    #1;
    checks++; if (abort !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wd_abort got=%b/%b exp=1/0", abort, busy); end
    tick; #1;
    checks++; if (grant !== 4'b0100 || abort !== 1'b0) begin failures++; $display("FAIL wd_next got=%b/%b exp=0100/0", grant, abort); end
    checks++; if (wdata !== 10'h277) begin failures++; $display("FAIL wd_wdata got=%h exp=277", wdata); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    req_valid = 4'b0001; set_data(0, 8'h01); #1;
    tick; tick; set_data(0, 8'h02); #1;
    checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL rm_pre got=%b exp=1", wr_en); end
    rst_n = 1'b0; #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rm_wr_en got=%b exp=0", wr_en); end
    checks++; if (grant !== 4'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin failures++; $display("FAIL rm_state got=%b/%b/%b exp=0000/0/0000", grant, busy, req_ready); end
    tick; rst_n = 1'b1; req_valid = 4'b1001; #1;
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL rm_idle got=%b exp=0000", grant); end
    tick; #1;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rm_regrant got=%b exp=0001", grant); end
    req_valid = '0;
  endtask

  task automatic test_rotation;
    do_reset;
    req_valid = 4'b0010; req_last = 4'b0010; set_data(1, 8'h31); #1;
    tick; #1;
    checks++; if (grant !== 4'b0010 || wr_en !== 1'b1) begin failures++; $display("FAIL rot_setup got=%b/%b exp=0010/1", grant, wr_en); end
    tick; req_valid = 4'b1010; req_last = 4'b1010; set_data(3, 8'h93); #1;
    checks++; if (grant !== 4'b0 || dut.ptr_q !== 2'd2) begin failures++; $display("FAIL rot_ptr got=%b/%0d exp=0000/2", grant, dut.ptr_q); end
    tick; #1;
    checks++; if (grant !== 4'b1000 || wdata !== 10'h393) begin failures++; $display("FAIL rot_first got=%b/%h exp=1000/393", grant, wdata); end
    tick; req_valid = 4'b0010; #1;
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL rot_gap got=%b exp=0000", grant); end
    tick; #1;
    checks++; if (grant !== 4'b0010 || wdata !== 10'h131) begin failures++; $display("FAIL rot_second got=%b/%h exp=0010/131", grant, wdata); end
    tick; req_valid = '0; req_last = '0;
  endtask

  task automatic test_full_toggle;
    do_reset;
    nb = 0; nr = 0;
    for (int k = 0; k < 20; k++) begin
      full = k[0];
      set_data(0, 8'(8'h40 + nb)); req_last[0] = (nb == 3); req_valid[0] = (nb < 4); #1;
      checks++; if (full === 1'b1 && wr_en !== 1'b0) begin failures++; $display("FAIL ft_full_wr cyc=%0d got=%b exp=0", k, wr_en); end
      if (wr_en === 1'b1) begin
        ew = {2'd0, 8'(8'h40 + nr)};
        checks++; if (wdata !== ew) begin failures++; $display("FAIL ft_beat cyc=%0d got=%h exp=%h", k, wdata, ew); end
        nr++;
      end
      if (req_valid[0] && req_ready[0]) nb++;
      tick;
    end
    checks++; if (nr !== 4) begin failures++; $display("FAIL ft_count got=%0d exp=4", nr); end
    full = 1'b0; req_valid = '0; req_last = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_watchdog;
    test_reset_mid;
    test_rotation;
    test_full_toggle;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
